fetch_issue_queue: RTL
======================

Name: fetch_issue_queue

Overview:
- Dual-width instruction buffer between the fetch stage and decode, i.e. directly upstream of the ID/EX register. Decode reads it as its IF/ID stage.
- Each cycle it accepts up to 2 fetched instructions with their PCs, and presents the oldest 2 to the two decode slots.
- It retires 0, 1 or 2 entries as directed by the issue logic.
- It decouples fetch bandwidth from dual-issue pairing stalls and provides the flush point on branch/jump redirect.

Parameters:
- DEPTH, 8, number of entries; power of 2, at least 4.
- XLEN, 32, width of instruction and PC.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- FlushD  in  1  redirect; empties the queue.
- FetchValid0  in  1  fetch slot 0 carries an instruction.
- FetchValid1  in  1  fetch slot 1 carries an instruction; only legal with FetchValid0.
- InstrF0  in  XLEN  fetch slot 0 instruction.
- InstrF1  in  XLEN  fetch slot 1 instruction.
- PCF0  in  XLEN  fetch slot 0 PC.
- PCF1  in  XLEN  fetch slot 1 PC.
- IssueCnt  in  2  number of entries decode consumes this cycle (0..2).
- FetchReady  out  1  queue can accept 2 instructions this cycle.
- ValidD0  out  1  head entry present.
- ValidD1  out  1  head+1 entry present.
- InstrD0  out  XLEN  head instruction, or NOP when invalid.
- InstrD1  out  XLEN  head+1 instruction, or NOP when invalid.
- PCD0  out  XLEN  head PC, or 0 when invalid.
- PCD1  out  XLEN  head+1 PC, or 0 when invalid.
- PCPlus4D0  out  XLEN  PCD0+4, or 0 when invalid.
- PCPlus4D1  out  XLEN  PCD1+4, or 0 when invalid.
- Count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH {pc, instr} entries. Registered head pointer, tail pointer and count; pointers wrap modulo DEPTH.
- Reset: asynchronous on rst; head = tail = count = 0. Storage contents need no reset.
- Outputs at reset and when empty: ValidD0 = ValidD1 = 0, InstrD0/1 = 32'h00000013 (NOP), PC/PCPlus4 = 0, Count = 0, FetchReady = 1.
- Output decode is purely from registered state, with zero input-to-output paths:
  - ValidD0 = (count >= 1); ValidD1 = (count >= 2).
  - D0 reads entry [head]; D1 reads entry [(head+1) mod DEPTH].
  - PCPlus4 is computed as PC + 4 truncated to XLEN.
- FetchReady = (DEPTH - count) >= 2, computed from start-of-cycle count. Same-cycle pops do not add space.
- Push, when FetchReady && !FlushD:
  - FetchValid0 writes slot 0 at [tail].
  - If FetchValid1 is also set, slot 1 writes at [tail+1].
  - tail advances by the number written.
  - FetchValid1 without FetchValid0 is ignored: nothing is written, and the simulation assertion fires.
- Push when !FetchReady: fetch inputs are ignored. Fetch must hold and re-present them.
- Pop, when !FlushD:
  - popped = min(IssueCnt, count); head advances by popped.
  - IssueCnt = 3 is treated as 2 (assertion).
  - IssueCnt > count is clamped (assertion).
- Simultaneous push and pop: count_next = count + pushed - popped. A pop of an entry and a push into a freed slot in the same cycle never collide, because push space excludes same-cycle pops.
- Push into an empty queue: the entry becomes visible on D0 in the next cycle. Minimum fetch-to-decode latency is 1 cycle.
- FlushD: next cycle head = tail = count = 0. Same-cycle push and pop are discarded. Priority is rst > FlushD > push/pop.
- Wrap-around: entries are written at DEPTH-1 and 0 in the same cycle when tail = DEPTH-1 and 2 are pushed. D1 reads index 0 when head = DEPTH-1.
- Full (count = DEPTH): FetchReady = 0, and pops still work. With count = DEPTH-1, FetchReady = 0.
- In-order guarantee: D0 is always older than D1, and entries leave in exactly push order.

Decomposition:
- Package fiq_pkg:
  - NOP_INSTR constant = 32'h00000013.
  - typedef fiq_entry_t packed struct {logic [31:0] pc; logic [31:0] instr;}.
  - Helper constant PTR_W = $clog2(DEPTH) for the default depth.
- Single module, no sub-module. The storage array is inferred inside it.

Test Plan:
- Reset mid-operation: fill to count=5, assert rst asynchronously between edges -> Count=0, ValidD0/1=0, InstrD0=32'h00000013, FetchReady=1 immediately, without waiting for a clock edge.
- Dual push then dual pop: push PC 0x100/0x104, next cycle IssueCnt=2 -> on cycle 1 PCD0=0x100, PCPlus4D0=0x104, PCD1=0x104, PCPlus4D1=0x108; after the pop Count=0.
- Single-issue stall pairing: queue holds 0x200,0x204,0x208; IssueCnt=1 -> next PCD0=0x204, PCD1=0x208, Count=2.
- Simultaneous push+pop at the full boundary: count=7 (DEPTH=8) -> FetchReady=0, push ignored; with IssueCnt=2 -> Count=5. Next cycle FetchReady=1; push 2 with IssueCnt=1 -> Count=6.
- Wrap-around: drive head=tail=7 via prior traffic, push 0x300/0x304 -> stored at indices 7 and 0; PCD0=0x300, PCD1=0x304 next cycle.
- Flush priority: count=4, FlushD=1 with FetchValid0/1=1 and IssueCnt=2 -> next cycle Count=0, ValidD0=0, and the new instructions are not present.

Source files
------------

// File: rtl/fiq_pkg.sv
// rtl/fiq_pkg.sv - shared constants and entry type for the fetch issue queue
package fiq_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int FIQ_DEPTH = 8;
    localparam int PTR_W = $clog2(FIQ_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fiq_entry_t;

endpackage

// File: rtl/fetch_issue_queue.sv
// rtl/fetch_issue_queue.sv - dual-width fetch-to-decode instruction buffer
module fetch_issue_queue
    import fiq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       FlushD,
    input  logic                       FetchValid0,
    input  logic                       FetchValid1,
    input  logic [XLEN-1:0]            InstrF0,
    input  logic [XLEN-1:0]            InstrF1,
    input  logic [XLEN-1:0]            PCF0,
    input  logic [XLEN-1:0]            PCF1,
    input  logic [1:0]                 IssueCnt,
    output logic                       FetchReady,
    output logic                       ValidD0,
    output logic                       ValidD1,
    output logic [XLEN-1:0]            InstrD0,
    output logic [XLEN-1:0]            InstrD1,
    output logic [XLEN-1:0]            PCD0,
    output logic [XLEN-1:0]            PCD1,
    output logic [XLEN-1:0]            PCPlus4D0,
    output logic [XLEN-1:0]            PCPlus4D1,
    output logic [$clog2(DEPTH):0]     Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   head, tail, head1, tail1;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [1:0]      push_n, pop_n, issue_sat;

    assign head1 = head + PW'(1);
    assign tail1 = tail + PW'(1);

    // Space is judged on start-of-cycle occupancy so a push never lands on a slot being popped.
    assign FetchReady = (CW'(DEPTH) - count) >= CW'(2);

    always_comb begin
        push_n = 2'd0;
        if (FetchReady && !FlushD && FetchValid0)
            push_n = FetchValid1 ? 2'd2 : 2'd1;
    end

    assign issue_sat = (IssueCnt == 2'd3) ? 2'd2 : IssueCnt;

    always_comb begin
        pop_n = 2'd0;
        if (!FlushD)
            pop_n = (count < CW'(issue_sat)) ? count[1:0] : issue_sat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (FlushD) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_n);
            tail  <= tail + PW'(push_n);
            count <= count + CW'(push_n) - CW'(pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (push_n != 2'd0) begin
            pc_mem[tail]    <= PCF0;
            instr_mem[tail] <= InstrF0;
            if (push_n == 2'd2) begin
                pc_mem[tail1]    <= PCF1;
                instr_mem[tail1] <= InstrF1;
            end
        end
    end

    assign ValidD0   = (count >= CW'(1));
    assign ValidD1   = (count >= CW'(2));
    assign InstrD0   = ValidD0 ? instr_mem[head]  : XLEN'(NOP_INSTR);
    assign InstrD1   = ValidD1 ? instr_mem[head1] : XLEN'(NOP_INSTR);
    assign PCD0      = ValidD0 ? pc_mem[head]  : '0;
    assign PCD1      = ValidD1 ? pc_mem[head1] : '0;
    assign PCPlus4D0 = ValidD0 ? pc_mem[head]  + XLEN'(4) : '0;
    assign PCPlus4D1 = ValidD1 ? pc_mem[head1] + XLEN'(4) : '0;
    assign Count     = count;

    // Illegal fetch/issue encodings are tolerated in hardware but flagged in simulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(FetchValid1 && !FetchValid0));
            assert (FlushD || IssueCnt != 2'd3);
            assert (FlushD || CW'(issue_sat) <= count);
        end
    end

endmodule
